// File: rtl/distance_meter_renderer.sv
// Walks the distance meter's high-score and current-score characters for one frame
// and issues one sprite-blit request per visible glyph over a valid/ready handshake.
module distance_meter_renderer #(
  parameter int MAX_DISTANCE_UNITS   = 5,
  parameter int HIGH_SCORE_OFFSET    = 3,
  parameter int MAX_HIGH_SCORE_UNITS = MAX_DISTANCE_UNITS + HIGH_SCORE_OFFSET,
  parameter int WIDTH                = 10,
  parameter int HEIGHT               = 13,
  parameter int DEST_WIDTH           = 11,
  parameter int X                    = 1148,
  parameter int HIGH_SCORE_X         = 948,
  parameter int Y                    = 20,
  parameter int TEXT_X               = 1294,
  parameter int TEXT_Y               = 2
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [MAX_DISTANCE_UNITS-1:0][3:0]    digits,
  input  logic [MAX_HIGH_SCORE_UNITS-1:0][3:0]  high_score,
  input  logic                                  paint,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  blit_valid,
  input  logic                                  blit_ready,
  output logic [10:0]                           blit_src_x,
  output logic [9:0]                            blit_src_y,
  output logic [10:0]                           blit_dst_x,
  output logic [9:0]                            blit_dst_y
);

  localparam int IDX_W = (MAX_HIGH_SCORE_UNITS > 1) ? $clog2(MAX_HIGH_SCORE_UNITS) : 1;
  localparam logic [IDX_W-1:0] HS_LAST  = IDX_W'(MAX_HIGH_SCORE_UNITS - 1);
  localparam logic [IDX_W-1:0] CUR_LAST = IDX_W'(MAX_DISTANCE_UNITS - 1);
  localparam logic [3:0] CODE_BLANK = 4'd12;

  // Every glyph and screen coordinate must fit the 11-bit x / 10-bit y fields.
  if (HEIGHT < 1 || TEXT_X + 15 * WIDTH * 2 > 2047 || TEXT_Y > 1023 || Y > 1023 ||
      X + (MAX_DISTANCE_UNITS - 1) * DEST_WIDTH * 2 > 2047 ||
      HIGH_SCORE_X + (MAX_HIGH_SCORE_UNITS - 1) * DEST_WIDTH * 2 > 2047) begin : g_param_check
    $error("distance_meter_renderer: coordinates overflow blit field widths");
  end

  typedef enum logic [1:0] {S_IDLE, S_HS, S_CUR, S_DONE} state_t;

  state_t                                state, nxt_state;
  logic [IDX_W-1:0]                      idx, nxt_idx;
  logic [3:0]                            nxt_code;
  logic                                  load;
  logic                                  hs_show_in;
  logic                                  advance;
  logic [MAX_DISTANCE_UNITS-1:0][3:0]    snap_digits;
  logic [MAX_HIGH_SCORE_UNITS-1:0][3:0]  snap_hs;
  logic                                  snap_paint;

  function automatic logic [10:0] src_x_of(input logic [3:0] code);
    return 11'(TEXT_X + int'(code) * WIDTH * 2);
  endfunction

  function automatic logic [10:0] dst_x_of(input logic hs, input logic [IDX_W-1:0] slot);
    return 11'((hs ? HIGH_SCORE_X : X) + int'(slot) * DEST_WIDTH * 2);
  endfunction

  always_comb begin
    hs_show_in = 1'b0;
    for (int k = HIGH_SCORE_OFFSET; k < MAX_HIGH_SCORE_UNITS; k++)
      if (high_score[k] != 4'd0) hs_show_in = 1'b1;
  end

  // A slot with no request (blank code) drops through in one cycle.
  assign advance = !blit_valid || blit_ready;

  // Next-slot selection: IDLE reads the live inputs so slot 0 is ready one cycle after start.
  always_comb begin
    nxt_state = state;
    nxt_idx   = idx;
    nxt_code  = 4'd0;
    load      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          nxt_idx = '0;
          if (hs_show_in) begin
            nxt_state = S_HS;
            nxt_code  = high_score[0];
          end else if (paint) begin
            nxt_state = S_CUR;
            nxt_code  = digits[0];
          end else begin
            nxt_state = S_DONE;
          end
        end
      end
      S_HS: begin
        if (advance) begin
          load = 1'b1;
          if (idx == HS_LAST) begin
            nxt_idx = '0;
            if (snap_paint) begin
              nxt_state = S_CUR;
              nxt_code  = snap_digits[0];
            end else begin
              nxt_state = S_DONE;
            end
          end else begin
            nxt_idx  = idx + 1'b1;
            nxt_code = snap_hs[nxt_idx];
          end
        end
      end
      S_CUR: begin
        if (advance) begin
          load = 1'b1;
          if (idx == CUR_LAST) begin
            nxt_idx   = '0;
            nxt_state = S_DONE;
          end else begin
            nxt_idx  = idx + 1'b1;
            nxt_code = snap_digits[nxt_idx];
          end
        end
      end
      default: begin
        load      = 1'b1;
        nxt_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      blit_valid  <= 1'b0;
      blit_src_x  <= '0;
      blit_src_y  <= '0;
      blit_dst_x  <= '0;
      blit_dst_y  <= '0;
      snap_digits <= '0;
      snap_hs     <= '0;
      snap_paint  <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        snap_digits <= digits;
        snap_hs     <= high_score;
        snap_paint  <= paint;
      end
      // Request fields only change on a slot transition, so they hold under backpressure.
      if (load) begin
        state      <= nxt_state;
        idx        <= nxt_idx;
        busy       <= (nxt_state != S_IDLE);
        done       <= (nxt_state == S_DONE);
        blit_valid <= 1'b0;
        if ((nxt_state == S_HS || nxt_state == S_CUR) && nxt_code < CODE_BLANK) begin
          blit_valid <= 1'b1;
          blit_src_x <= src_x_of(nxt_code);
          blit_src_y <= 10'(TEXT_Y);
          blit_dst_x <= dst_x_of(nxt_state == S_HS, nxt_idx);
          blit_dst_y <= 10'(Y);
        end
      end
    end
  end

endmodule

// File: tb/tb_distance_meter_renderer.sv
// Self-checking bench: directed and randomized frames against a list-based reference of expected blits.
module tb_distance_meter_renderer;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, paint = 1'b0, blit_ready = 1'b0;
  logic [4:0][3:0] digits = '0;
  logic [7:0][3:0] high_score = '0;
  logic busy, done, blit_valid;
  logic [10:0] blit_src_x, blit_dst_x;
  logic [9:0]  blit_src_y, blit_dst_y;

  distance_meter_renderer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .digits(digits), .high_score(high_score),
    .paint(paint), .busy(busy), .done(done), .blit_valid(blit_valid), .blit_ready(blit_ready),
    .blit_src_x(blit_src_x), .blit_src_y(blit_src_y), .blit_dst_x(blit_dst_x), .blit_dst_y(blit_dst_y)
  );

  always #5 clk = ~clk;

  typedef logic [41:0] blit_t;
  int total = 0, bad = 0;
  blit_t exp_q[$], obs_q[$];
  int exp_cyc, done_cnt, done_cyc, hold_viol;
  logic rst_valid, rst_busy;

  function automatic blit_t mk(input int sx, input int dx);
    return {11'(sx), 10'd2, 11'(dx), 10'd20};
  endfunction

  // Reference: visible glyphs in screen order, one cycle per slot with ready high.
  function automatic void build_exp();
    bit hs_show = 1'b0;
    exp_q.delete();
    for (int j = 3; j < 8; j++) if (high_score[j] != 4'd0) hs_show = 1'b1;
    exp_cyc = 1;
    if (hs_show) begin
      exp_cyc += 8;
      for (int j = 0; j < 8; j++)
        if (int'(high_score[j]) < 12) exp_q.push_back(mk(1294 + 20 * int'(high_score[j]), 948 + 22 * j));
    end
    if (paint) begin
      exp_cyc += 5;
      for (int i = 0; i < 5; i++)
        if (int'(digits[i]) < 12) exp_q.push_back(mk(1294 + 20 * int'(digits[i]), 1148 + 22 * i));
    end
  endfunction

  function automatic void set_frame(input int d[5], input int h[8], input logic p);
    for (int i = 0; i < 5; i++) digits[i] = 4'(d[i]);
    for (int j = 0; j < 8; j++) high_score[j] = 4'(h[j]);
    paint = p;
  endfunction

  // Pulses start, then runs n_cyc cycles recording accepted blits, done pulses and hold violations.
  task automatic collect(input int n_cyc, input int stall_req, input int stall_len,
                         input bit rand_ready, input int mid_start_cyc, input int rst_cyc);
    int stalled = 0, acc = 0;
    blit_t held, cur;
    bit have_held = 1'b0;
    obs_q.delete(); done_cnt = 0; done_cyc = -1; hold_viol = 0; rst_valid = 1'b0; rst_busy = 1'b0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int cyc = 1; cyc <= n_cyc; cyc++) begin
      if (cyc == mid_start_cyc) begin
        start = 1'b1;
        for (int i = 0; i < 5; i++) digits[i] = 4'($urandom_range(0, 9));
        paint = ~paint;
      end else start = 1'b0;
      if (rand_ready) blit_ready = 1'($urandom_range(0, 1));
      else begin
        blit_ready = !(blit_valid && acc == stall_req && stalled < stall_len);
        if (!blit_ready) stalled++;
      end
      if (cyc == rst_cyc) begin
        rst_n = 1'b0; #1;
        rst_valid = blit_valid; rst_busy = busy;
      end
      if (cyc == rst_cyc + 2) rst_n = 1'b1;
      @(negedge clk);
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (have_held && !blit_valid && rst_n) hold_viol++;
      if (blit_valid) begin
        cur = {blit_src_x, blit_src_y, blit_dst_x, blit_dst_y};
        if (have_held && cur !== held) hold_viol++;
        if (blit_ready) begin obs_q.push_back(cur); acc++; have_held = 1'b0; end
        else begin held = cur; have_held = 1'b1; end
      end else have_held = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0; blit_ready = 1'b0; rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; blit_ready = 1'b1;
    repeat (2) @(negedge clk);
    total++; if ({busy, done, blit_valid} !== 3'b000) begin bad++; $display("FAIL reset_ctrl: got %b want 000", {busy, done, blit_valid}); end
    total++; if ({blit_src_x, blit_src_y, blit_dst_x, blit_dst_y} !== 42'd0) begin bad++; $display("FAIL reset_data: got %h want 0", {blit_src_x, blit_src_y, blit_dst_x, blit_dst_y}); end
    blit_ready = 1'b0;
  endtask

  task automatic test_order();
    int d[5] = '{0, 0, 1, 2, 3};
    int h[8] = '{10, 11, 12, 0, 0, 4, 5, 6};
    set_frame(d, h, 1'b1); build_exp();
    collect(20, -1, 0, 1'b0, -1, -1);
    total++; if (obs_q.size() !== 12) begin bad++; $display("FAIL order_count: got %0d want 12", obs_q.size()); end
    total++; if (obs_q.size() > 0 && obs_q[0] !== mk(1494, 948)) begin bad++; $display("FAIL order_H: got %h want %h", obs_q[0], mk(1494, 948)); end
    total++; if (obs_q.size() > 1 && obs_q[1] !== mk(1514, 970)) begin bad++; $display("FAIL order_I: got %h want %h", obs_q[1], mk(1514, 970)); end
    total++; if (obs_q.size() > 11 && obs_q[11] !== mk(1354, 1236)) begin bad++; $display("FAIL order_last: got %h want %h", obs_q[11], mk(1354, 1236)); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL order_len: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      total++; if (obs_q[k] !== exp_q[k]) begin bad++; $display("FAIL order_blit%0d: got %h want %h", k, obs_q[k], exp_q[k]); end
    end
    total++; if (done_cyc !== 14 || done_cnt !== 1) begin bad++; $display("FAIL order_done: got cyc %0d cnt %0d want cyc 14 cnt 1", done_cyc, done_cnt); end
  endtask

  task automatic test_hs_hidden();
    int d[5] = '{0, 0, 1, 2, 3};
    int h[8] = '{10, 11, 12, 0, 0, 0, 0, 0};
    set_frame(d, h, 1'b1); build_exp();
    collect(12, -1, 0, 1'b0, -1, -1);
    total++; if (obs_q.size() != 5) begin bad++; $display("FAIL hidden_count: got %0d want 5", obs_q.size()); end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      total++; if (obs_q[k] !== exp_q[k]) begin bad++; $display("FAIL hidden_blit%0d: got %h want %h", k, obs_q[k], exp_q[k]); end
    end
    total++; if (done_cyc !== 6 || done_cnt !== 1) begin bad++; $display("FAIL hidden_done: got cyc %0d cnt %0d want cyc 6 cnt 1", done_cyc, done_cnt); end
  endtask

  task automatic test_no_paint();
    int d[5] = '{9, 8, 7, 6, 5};
    int h[8] = '{10, 11, 12, 0, 3, 0, 1, 7};
    int far = 0;
    set_frame(d, h, 1'b0); build_exp();
    collect(16, -1, 0, 1'b0, -1, -1);
    foreach (obs_q[k]) if (int'(obs_q[k][20:10]) >= 1148) far++;
    total++; if (obs_q.size() != 7 || far != 0) begin bad++; $display("FAIL nopaint_count: got %0d (cur %0d) want 7 (cur 0)", obs_q.size(), far); end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      total++; if (obs_q[k] !== exp_q[k]) begin bad++; $display("FAIL nopaint_blit%0d: got %h want %h", k, obs_q[k], exp_q[k]); end
    end
    total++; if (done_cnt !== 1 || done_cyc !== exp_cyc) begin bad++; $display("FAIL nopaint_done: got cyc %0d cnt %0d want cyc %0d cnt 1", done_cyc, done_cnt, exp_cyc); end
  endtask

  task automatic test_backpressure();
    int d[5] = '{1, 2, 3, 4, 5};
    int h[8] = '{10, 11, 12, 0, 9, 8, 0, 2};
    set_frame(d, h, 1'b1); build_exp();
    collect(24, 1, 4, 1'b0, -1, -1);
    total++; if (hold_viol !== 0) begin bad++; $display("FAIL bp_hold: got %0d violations want 0", hold_viol); end
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL bp_len: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      total++; if (obs_q[k] !== exp_q[k]) begin bad++; $display("FAIL bp_blit%0d: got %h want %h", k, obs_q[k], exp_q[k]); end
    end
    total++; if (done_cyc !== exp_cyc + 4 || done_cnt !== 1) begin bad++; $display("FAIL bp_done: got cyc %0d cnt %0d want cyc %0d cnt 1", done_cyc, done_cnt, exp_cyc + 4); end
  endtask

  task automatic test_mid_start();
    int d[5] = '{4, 0, 4, 0, 4};
    int h[8] = '{10, 11, 12, 0, 0, 0, 3, 3};
    set_frame(d, h, 1'b1); build_exp();
    collect(24, -1, 0, 1'b0, 4, -1);
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL midstart_len: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      total++; if (obs_q[k] !== exp_q[k]) begin bad++; $display("FAIL midstart_blit%0d: got %h want %h", k, obs_q[k], exp_q[k]); end
    end
    total++; if (done_cnt !== 1 || done_cyc !== exp_cyc) begin bad++; $display("FAIL midstart_done: got cyc %0d cnt %0d want cyc %0d cnt 1", done_cyc, done_cnt, exp_cyc); end
  endtask

  task automatic test_reset_mid();
    int d[5] = '{0, 7, 1, 2, 3};
    int h[8] = '{10, 11, 12, 0, 2, 4, 5, 6};
    set_frame(d, h, 1'b1);
    collect(20, -1, 0, 1'b0, -1, 10);
    total++; if ({rst_valid, rst_busy} !== 2'b00) begin bad++; $display("FAIL rstmid_async: got valid %b busy %b want 0 0", rst_valid, rst_busy); end
    total++; if (done_cnt !== 0) begin bad++; $display("FAIL rstmid_nodone: got %0d want 0", done_cnt); end
    build_exp();
    collect(20, -1, 0, 1'b0, -1, -1);
    total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rstmid_len: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      total++; if (obs_q[k] !== exp_q[k]) begin bad++; $display("FAIL rstmid_blit%0d: got %h want %h", k, obs_q[k], exp_q[k]); end
    end
    total++; if (done_cnt !== 1 || done_cyc !== exp_cyc) begin bad++; $display("FAIL rstmid_done: got cyc %0d cnt %0d want cyc %0d cnt 1", done_cyc, done_cnt, exp_cyc); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 16; f++) begin
      bit rr = f[0];
      for (int i = 0; i < 5; i++) digits[i] = 4'($urandom_range(0, 9));
      for (int j = 0; j < 3; j++) high_score[j] = 4'($urandom_range(0, 15));
      for (int j = 3; j < 8; j++) high_score[j] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 12));
      paint = ($urandom_range(0, 3) != 0);
      build_exp();
      collect(rr ? 90 : 20, -1, 0, rr, -1, -1);
      total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL rand%0d_len: got %0d want %0d", f, obs_q.size(), exp_q.size()); end
      for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
        total++; if (obs_q[k] !== exp_q[k]) begin bad++; $display("FAIL rand%0d_blit%0d: got %h want %h", f, k, obs_q[k], exp_q[k]); end
      end
      total++; if (hold_viol !== 0) begin bad++; $display("FAIL rand%0d_hold: got %0d want 0", f, hold_viol); end
      total++; if (done_cnt !== 1) begin bad++; $display("FAIL rand%0d_done_cnt: got %0d want 1", f, done_cnt); end
      if (!rr) begin
        total++; if (done_cyc !== exp_cyc) begin bad++; $display("FAIL rand%0d_done_cyc: got %0d want %0d", f, done_cyc, exp_cyc); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_order();
    test_hs_hidden();
    test_no_paint();
    test_backpressure();
    test_mid_start();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
